// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, ALU opcodes and the EX control payload.
package pipe_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned ALU_CTL_W  = 3;

    localparam logic [ALU_CTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = 3'b010;
    localparam logic [ALU_CTL_W-1:0] ALU_AND = 3'b110;
    localparam logic [ALU_CTL_W-1:0] ALU_OR  = 3'b100;

    typedef struct packed {
        logic                 valid;
        logic                 mem_read;
        logic                 mem_write;
        logic                 reg_write;
        logic [ALU_CTL_W-1:0] alu_ctl;
    } ex_ctl_t;

    // Control word for an injected bubble: nothing valid, nothing written.
    localparam ex_ctl_t BUBBLE_CTL = '{valid: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                       reg_write: 1'b0, alu_ctl: ALU_ADD};

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM result beats MEM/WB result beats registered data; x0 never forwarded.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter bit          EN     = 1'b1
) (
    input  logic [REG_AW-1:0] src,
    input  logic [XLEN-1:0]   reg_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   data_c
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = EN && mem_reg_write && (mem_rd != '0) && (mem_rd == src);
        wb_hit  = EN && wb_reg_write && (wb_rd != '0) && (wb_rd == src);
        if (mem_hit) begin
            data_c = mem_result;
        end else if (wb_hit) begin
            data_c = wb_result;
        end else begin
            data_c = reg_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and ALU operand forwarding.
// Optional feature: define FORWARD_EN for forwarding muxes; otherwise RAW hazards stall until clear.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alu_src,
    input  logic [2:0]        id_alu_ctl,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic              stall_id,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [2:0]        alu_ctl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

`ifdef FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    ex_ctl_t           ctl_q, ctl_d;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
    logic              alu_src_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic              rs2_used_c, load_use_c, raw_ex_c, raw_mem_c, hazard_c, bubble_c;
    logic [XLEN-1:0]   rs1_fwd_c, rs2_fwd_c;

    // rs2 only matters for register-register ops and as store data.
    always_comb begin
        rs2_used_c = ~id_alu_src | id_mem_write;
        load_use_c = ctl_q.valid & ctl_q.mem_read & (rd_q != '0)
                   & ((rd_q == id_rs1) | ((rd_q == id_rs2) & rs2_used_c));
        raw_ex_c   = ctl_q.valid & ctl_q.reg_write & (rd_q != '0)
                   & ((rd_q == id_rs1) | ((rd_q == id_rs2) & rs2_used_c));
        raw_mem_c  = mem_reg_write & (mem_rd != '0)
                   & ((mem_rd == id_rs1) | ((mem_rd == id_rs2) & rs2_used_c));
        hazard_c   = id_valid & (FWD_ON ? load_use_c : (load_use_c | raw_ex_c | raw_mem_c));
        bubble_c   = flush | hazard_c;
    end

    assign stall_id = hazard_c & ~flush;

    always_comb begin
        ctl_d = BUBBLE_CTL;
        if (!bubble_c) begin
            ctl_d.valid     = id_valid;
            ctl_d.mem_read  = id_mem_read & id_valid;
            ctl_d.mem_write = id_mem_write & id_valid;
            ctl_d.reg_write = id_reg_write & id_valid;
            ctl_d.alu_ctl   = id_alu_ctl;
        end
    end

    // Pipeline register; data fields are cleared whenever a bubble is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q      <= BUBBLE_CTL;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            alu_src_q  <= 1'b0;
        end else begin
            ctl_q      <= ctl_d;
            rs1_q      <= bubble_c ? '0 : id_rs1;
            rs2_q      <= bubble_c ? '0 : id_rs2;
            rd_q       <= bubble_c ? '0 : id_rd;
            rs1_data_q <= bubble_c ? '0 : id_rs1_data;
            rs2_data_q <= bubble_c ? '0 : id_rs2_data;
            imm_q      <= bubble_c ? '0 : id_imm;
            alu_src_q  <= bubble_c ? 1'b0 : id_alu_src;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_id && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .EN(FWD_ON)) u_fwd_rs1 (
        .src(rs1_q), .reg_data(rs1_data_q),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .data_c(rs1_fwd_c)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .EN(FWD_ON)) u_fwd_rs2 (
        .src(rs2_q), .reg_data(rs2_data_q),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .data_c(rs2_fwd_c)
    );

    assign alu_a         = rs1_fwd_c;
    assign alu_b         = alu_src_q ? imm_q : rs2_fwd_c;
    assign ex_store_data = rs2_fwd_c;
    assign alu_ctl       = ctl_q.alu_ctl;
    assign ex_rd         = rd_q;
    assign ex_valid      = ctl_q.valid;
    assign ex_mem_read   = ctl_q.mem_read;
    assign ex_mem_write  = ctl_q.mem_write;
    assign ex_reg_write  = ctl_q.reg_write;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow FORWARD_EN when it is defined.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 3;
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk, rst_n;
    logic              id_valid, id_alu_src, id_mem_read, id_mem_write, id_reg_write, flush;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
    logic [2:0]        id_alu_ctl, alu_ctl;
    logic              mem_reg_write, wb_reg_write;
    logic              stall_id, ex_mem_read, ex_mem_write, ex_reg_write, ex_valid;
    logic [XLEN-1:0]   alu_a, alu_b, ex_store_data;
    logic [CNT_W-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] exp_cnt;

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctl(id_alu_ctl),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .stall_id(stall_id), .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_valid(ex_valid), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_idle();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_alu_src = 1'b0;
        id_alu_ctl = ALU_ADD; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_reg_write = 1'b0; flush = 1'b0;
    endtask

    task automatic ext_idle();
        mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
        wb_rd = '0; wb_reg_write = 1'b0; wb_result = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [2:0] op);
        id_idle();
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_alu_ctl = op; id_reg_write = 1'b1;
    endtask

    // lw x4, 0(x1)
    task automatic drive_lw4();
        id_idle();
        id_valid = 1'b1; id_rs1 = 5'd1; id_rd = 5'd4; id_rs1_data = 32'h200;
        id_alu_src = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1;
    endtask

    // sub x5, x4, x6 with stale x4
    task automatic drive_sub();
        drive_alu(5'd4, 5'd6, 5'd5, 32'h11, 32'h6, ALU_SUB);
    endtask

    task automatic test_reset();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0h want 0", ex_valid); end
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0h want 0", stall_cnt); end
        checks++; if (alu_ctl !== 3'b000) begin errors++; $display("FAIL reset_alu_ctl: got %0h want 0", alu_ctl); end
        checks++; if ({ex_mem_read, ex_mem_write, ex_reg_write} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %0b want 000", {ex_mem_read, ex_mem_write, ex_reg_write}); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_ex_rd: got %0h want 0", ex_rd); end
        checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL reset_alu_a: got %0h want 0", alu_a); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall_id: got %0h want 0", stall_id); end
    endtask

    task automatic test_add();
        drive_alu(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, ALU_ADD);
        tick();
        id_idle();
        #1;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_ex_valid: got %0h want 1", ex_valid); end
        checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_reg_write: got %0h want 1", ex_reg_write); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL add_ex_rd: got %0h want 3", ex_rd); end
        checks++; if (alu_ctl !== 3'b000) begin errors++; $display("FAIL add_alu_ctl: got %0h want 0", alu_ctl); end
        checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL add_alu_a: got %0h want 5", alu_a); end
        checks++; if (alu_b !== 32'd7) begin errors++; $display("FAIL add_alu_b: got %0h want 7", alu_b); end
        checks++; if (ex_store_data !== 32'd7) begin errors++; $display("FAIL add_store_data: got %0h want 7", ex_store_data); end
    endtask

    task automatic test_imm_store();
        id_idle();
        id_valid = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd8; id_rs1_data = 32'h100; id_rs2_data = 32'h9;
        id_imm = 32'hFFFF_FFF0; id_alu_src = 1'b1; id_mem_write = 1'b1; id_alu_ctl = ALU_OR;
        tick();
        #1;
        checks++; if (alu_b !== 32'hFFFF_FFF0) begin errors++; $display("FAIL imm_alu_b: got %0h want fffffff0", alu_b); end
        checks++; if (alu_a !== 32'h100) begin errors++; $display("FAIL imm_alu_a: got %0h want 100", alu_a); end
        checks++; if (ex_store_data !== 32'h9) begin errors++; $display("FAIL imm_store_data: got %0h want 9", ex_store_data); end
        checks++; if ({ex_mem_write, ex_reg_write} !== 2'b10) begin errors++; $display("FAIL imm_flags: got %0b want 10", {ex_mem_write, ex_reg_write}); end
        checks++; if (alu_ctl !== ALU_OR) begin errors++; $display("FAIL imm_alu_ctl: got %0h want %0h", alu_ctl, ALU_OR); end
        // Same store with id_valid low: flags are gated, other fields still load.
        id_valid = 1'b0; id_alu_ctl = ALU_AND;
        tick();
        id_idle();
        #1;
        checks++; if ({ex_valid, ex_mem_write} !== 2'b00) begin errors++; $display("FAIL gate_flags: got %0b want 00", {ex_valid, ex_mem_write}); end
        checks++; if (alu_ctl !== ALU_AND) begin errors++; $display("FAIL gate_alu_ctl: got %0h want %0h", alu_ctl, ALU_AND); end
    endtask

    task automatic test_forward();
        drive_alu(5'd1, 5'd2, 5'd9, 32'h55, 32'h66, ALU_ADD);
        tick();
        id_idle();
        mem_rd = 5'd1; mem_reg_write = 1'b1; mem_result = 32'h10;
        wb_rd = 5'd1; wb_reg_write = 1'b1; wb_result = 32'h20;
        #1;
        checks++; if (alu_a !== (FWD ? 32'h10 : 32'h55)) begin errors++; $display("FAIL fwd_priority: got %0h want %0h", alu_a, FWD ? 32'h10 : 32'h55); end
        checks++; if (alu_b !== 32'h66) begin errors++; $display("FAIL fwd_rs2_nomatch: got %0h want 66", alu_b); end
        mem_reg_write = 1'b0;
        #1;
        checks++; if (alu_a !== (FWD ? 32'h20 : 32'h55)) begin errors++; $display("FAIL fwd_wb: got %0h want %0h", alu_a, FWD ? 32'h20 : 32'h55); end
        wb_rd = 5'd2;
        #1;
        checks++; if (alu_a !== 32'h55) begin errors++; $display("FAIL fwd_none: got %0h want 55", alu_a); end
        checks++; if (alu_b !== (FWD ? 32'h20 : 32'h66)) begin errors++; $display("FAIL fwd_wb_rs2: got %0h want %0h", alu_b, FWD ? 32'h20 : 32'h66); end
        mem_rd = 5'd2; mem_reg_write = 1'b1; mem_result = 32'h10;
        #1;
        checks++; if (ex_store_data !== (FWD ? 32'h10 : 32'h66)) begin errors++; $display("FAIL fwd_store: got %0h want %0h", ex_store_data, FWD ? 32'h10 : 32'h66); end
        ext_idle();
    endtask

    task automatic test_x0();
        drive_alu(5'd0, 5'd0, 5'd10, 32'h33, 32'h44, ALU_ADD);
        tick();
        id_idle();
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hFF;
        wb_rd = 5'd0; wb_reg_write = 1'b1; wb_result = 32'hEE;
        #1;
        checks++; if (alu_a !== 32'h33) begin errors++; $display("FAIL x0_alu_a: got %0h want 33", alu_a); end
        checks++; if (alu_b !== 32'h44) begin errors++; $display("FAIL x0_alu_b: got %0h want 44", alu_b); end
        ext_idle();
    endtask

    task automatic test_load_use();
        drive_lw4();
        tick();
        drive_sub();
        #1;
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0h want 1", stall_id); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt_before: got %0h want %0h", stall_cnt, exp_cnt); end
        tick();
        exp_cnt = exp_cnt + 3'd1;
        mem_rd = 5'd4; mem_reg_write = 1'b1; mem_result = 32'h99;
        #1;
        checks++; if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000) begin errors++; $display("FAIL lu_bubble: got %0b want 000", {ex_valid, ex_mem_read, ex_reg_write}); end
        checks++; if (alu_ctl !== 3'b000) begin errors++; $display("FAIL lu_bubble_ctl: got %0h want 0", alu_ctl); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt: got %0h want %0h", stall_cnt, exp_cnt); end
`ifdef FORWARD_EN
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL lu_release: got %0h want 0", stall_id); end
`else
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL raw_mem_stall: got %0h want 1", stall_id); end
        tick();
        exp_cnt = exp_cnt + 3'd1;
        mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
        wb_rd = 5'd4; wb_reg_write = 1'b1; wb_result = 32'h99;
        id_rs1_data = 32'h99;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL raw_bubble2: got %0h want 0", ex_valid); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL raw_cnt2: got %0h want %0h", stall_cnt, exp_cnt); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL raw_release: got %0h want 0", stall_id); end
`endif
        tick();
        id_idle();
        ext_idle();
        wb_rd = 5'd4; wb_reg_write = 1'b1; wb_result = 32'h99;
        #1;
        checks++; if ({ex_valid, ex_reg_write} !== 2'b11) begin errors++; $display("FAIL lu_issue: got %0b want 11", {ex_valid, ex_reg_write}); end
        checks++; if (alu_ctl !== ALU_SUB) begin errors++; $display("FAIL lu_alu_ctl: got %0h want %0h", alu_ctl, ALU_SUB); end
        checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL lu_ex_rd: got %0h want 5", ex_rd); end
        checks++; if (alu_a !== 32'h99) begin errors++; $display("FAIL lu_alu_a: got %0h want 99", alu_a); end
        checks++; if (alu_b !== 32'h6) begin errors++; $display("FAIL lu_alu_b: got %0h want 6", alu_b); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt_after: got %0h want %0h", stall_cnt, exp_cnt); end
        ext_idle();
    endtask

    task automatic test_flush();
        drive_lw4();
        tick();
        drive_sub();
        flush = 1'b1;
        #1;
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0h want 0", stall_id); end
        tick();
        id_idle();
        #1;
        checks++; if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) begin errors++; $display("FAIL flush_bubble: got %0b want 000", {ex_valid, ex_reg_write, ex_mem_read}); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL flush_cnt: got %0h want %0h", stall_cnt, exp_cnt); end
        drive_alu(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, ALU_ADD);
        flush = 1'b1;
        tick();
        id_idle();
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_plain: got %0h want 0", ex_valid); end
    endtask

    task automatic test_reset_mid_stall();
        drive_lw4();
        tick();
        drive_sub();
        #1;
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %0h want 1", stall_id); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        checks++; if ({ex_valid, ex_mem_read} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags: got %0b want 00", {ex_valid, ex_mem_read}); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %0h want 0", stall_id); end
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0h want 0", stall_cnt); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL rst_release_stall: got %0h want 0", stall_id); end
        tick();
        id_idle();
        #1;
        checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd5}) begin errors++; $display("FAIL rst_release_issue: got %0h want %0h", {ex_valid, ex_rd}, {1'b1, 5'd5}); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 9; i++) begin
            drive_lw4();
            tick();
            drive_sub();
            #1;
            checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d]: got %0h want 1", i, stall_id); end
            tick();
            id_idle();
            #1;
            if (exp_cnt != 3'd7) exp_cnt = exp_cnt + 3'd1;
            checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt[%0d]: got %0h want %0h", i, stall_cnt, exp_cnt); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        id_idle();
        ext_idle();
        exp_cnt = '0;
        #3;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_add();
        test_imm_store();
        test_forward();
        test_x0();
        test_load_use();
        test_flush();
        test_reset_mid_stall();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
